mem_arbiter: RTL and testbench

Two-port arbiter that shares a single-port word memory between the CPU's instruction-fetch path and its load/store path. It sits between the CPU datapath (fetch unit and memory stage) and the unified instruction/data RAM. The CPU stalls on each port until that port's ready pulse. Data accesses have priority, and a starvation counter guarantees that instruction fetch still makes forward progress.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_lat_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states, owner codes
// and a width helper used to size the counters.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter that times the memory latency; done is high once the
// count has reached zero.
module lat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = cnt_width(MEM_LAT - 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register updates
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store.
// Data wins ties unless fetch has been passed over MAX_DBURST times in a row.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_DBURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = cnt_width(MAX_DBURST);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DBURST);

  state_t        state;
  logic          owner;
  logic [SW-1:0] starve_cnt;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          grant;
  logic          grant_d;
  logic          lat_done;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant   = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      grant   = if_req | d_req;
      grant_d = d_req & (~if_req | (starve_cnt != SMAX));
    end
  end

  lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst_n(rst_n),
    .load (grant),
    .dec  ((state == ISSUE) || (state == WAIT)),
    .done (lat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state  <= ISSUE;
            mem_en <= 1'b1;
            if (grant_d) begin
              owner     <= OWN_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // Only data grants that actually bypass a waiting fetch count.
              if (if_req && (starve_cnt != SMAX)) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              owner      <= OWN_IF;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end
          end
        end
        ISSUE, WAIT: begin
          if (lat_done) begin
            state    <= DONE;
            if_ready <= (owner == OWN_IF);
            d_ready  <= (owner == OWN_D);
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
          if (owner == OWN_IF) if_rdata_q <= mem_rdata;
          else                 d_rdata_q  <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data flows straight through during DONE and is held afterwards.
  assign if_rdata = (state == DONE && owner == OWN_IF) ? mem_rdata : if_rdata_q;
  assign d_rdata  = (state == DONE && owner == OWN_D)  ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 2, 3) on a shared clock, each
// with a latency-accurate RAM model and a scoreboard monitor.
module tb_mem_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic        if_ready  [N];
  logic [31:0] if_rdata  [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_ready   [N];
  logic [31:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];

  iss_t issq [N][$];
  rsp_t rspq [N][$];

  int n_tests = 0;
  int n_fail  = 0;
  bit starve_mode = 1'b0;
  bit b2b_mode    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h2010_0005 : (32'h5A00_0000 | a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : u
    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(g + 1), .MAX_DBURST(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ready (if_ready[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ready  (d_ready[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );

    logic [31:0] ram  [256];
    logic [31:0] pipe [g + 1];

    initial for (int i = 0; i < 256; i++) ram[i] = init_word(32'(i * 4));

    // Read data appears MEM_LAT cycles after the strobe cycle.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) ram[mem_addr[g][9:2]] = mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? ram[mem_addr[g][9:2]] : 32'hBAD0_BAD0;
      for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
    end
    assign mem_rdata[g] = pipe[g];

    int en_cyc = -100;
    int prev_starve = 0;
    bit in_b2b = 1'b0;

    always @(negedge clk) begin : mon
      iss_t e;
      rsp_t r;
      if (rst_n) begin
        if (mem_we[g]) check("we_only_in_issue", 32'(mem_en[g]), 32'd1);
        if (mem_en[g]) begin
          check("issue_expected", 32'(issq[g].size() != 0), 32'd1);
          if (issq[g].size() != 0) begin
            e = issq[g].pop_front();
            check("mem_addr", mem_addr[g], e.addr);
            check("mem_we", 32'(mem_we[g]), 32'(e.we));
            if (e.we) check("mem_wdata", mem_wdata[g], e.wdata);
            if (starve_mode && !e.is_d) check("starve_cnt_before_if", 32'(prev_starve), 32'd4);
          end
          if (b2b_mode && in_b2b) check("b2b_en_gap", 32'(cyc - en_cyc), 32'(g + 3));
          in_b2b = b2b_mode;
          en_cyc = cyc;
        end
        if (if_ready[g] || d_ready[g]) begin
          check("single_ready", 32'(if_ready[g] & d_ready[g]), 32'd0);
          check("en_to_ready", 32'(cyc - en_cyc), 32'(g + 1));
          check("ready_expected", 32'(rspq[g].size() != 0), 32'd1);
          if (rspq[g].size() != 0) begin
            r = rspq[g].pop_front();
            check("ready_port_is_d", 32'(d_ready[g]), 32'(r.is_d));
            if (r.chk) check("rdata", r.is_d ? d_rdata[g] : if_rdata[g], r.data);
          end
        end
        prev_starve = 32'(dut.starve_cnt);
      end
    end
  end

  task automatic expect_acc(input int g, input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit rsp, input bit chk,
                            input logic [31:0] data);
    issq[g].push_back('{is_d: is_d, we: we, addr: addr, wdata: wdata});
    if (rsp) rspq[g].push_back('{is_d: is_d, chk: chk, data: data});
  endtask

  // Waits for nd data and ni fetch ready pulses, dropping each request after its
  // last pulse; if_step moves the fetch address after each intermediate pulse.
  task automatic serve(input int g, input int nd, input int ni, input int if_step, input bit lat_chk);
    int dc = 0;
    int ic = 0;
    int t = 0;
    int start = cyc;
    bit first = 1'b1;
    while ((dc < nd || ic < ni) && t < 300) begin
      @(negedge clk);
      t++;
      if (lat_chk && first && (d_ready[g] || if_ready[g])) begin
        first = 1'b0;
        check("req_to_ready", 32'(cyc - start), 32'(g + 2));
      end
      if (d_ready[g]) begin
        dc++;
        if (dc >= nd) d_req[g] = 1'b0;
      end
      if (if_ready[g]) begin
        ic++;
        if (ic >= ni) if_req[g] = 1'b0;
        else if_addr[g] = if_addr[g] + 32'(if_step);
      end
    end
    check("serve_within_budget", 32'(dc >= nd && ic >= ni), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int g = 0; g < N; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0; d_req[g] = 1'b0;
      d_we[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_ready", 32'(if_ready[0]), 32'd0);
    check("rst_mem_en", 32'(mem_en[0]), 32'd0);
    check("rst_mem_addr", mem_addr[0], 32'd0);
    check("rst_d_rdata", d_rdata[0], 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single fetch, MEM_LAT=1.
    expect_acc(0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 32'h2010_0005);
    @(posedge clk); #1;
    if_addr[0] = 32'h4; if_req[0] = 1'b1;
    serve(0, 0, 1, 0, 1'b1);

    // Back-to-back fetches with if_req held across if_ready.
    for (int i = 0; i < 3; i++)
      expect_acc(0, 1'b0, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 1'b1, 1'b1, init_word(32'h10 + 32'(4 * i)));
    b2b_mode = 1'b1;
    @(posedge clk); #1;
    if_addr[0] = 32'h10; if_req[0] = 1'b1;
    serve(0, 0, 3, 4, 1'b0);
    b2b_mode = 1'b0;

    // Simultaneous requests: data first, then fetch.
    expect_acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, init_word(32'h20));
    expect_acc(0, 1'b0, 1'b0, 32'h24, 32'h0, 1'b1, 1'b1, init_word(32'h24));
    @(posedge clk); #1;
    d_addr[0] = 32'h20; d_we[0] = 1'b0; d_req[0] = 1'b1;
    if_addr[0] = 32'h24; if_req[0] = 1'b1;
    serve(0, 1, 1, 0, 1'b1);

    // Starvation: D,D,D,D,IF,D,D,D,D,IF.
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) expect_acc(0, 1'b0, 1'b0, 32'h34, 32'h0, 1'b1, 1'b1, init_word(32'h34));
      else                  expect_acc(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, init_word(32'h30));
    end
    starve_mode = 1'b1;
    @(posedge clk); #1;
    d_addr[0] = 32'h30; d_req[0] = 1'b1;
    if_addr[0] = 32'h34; if_req[0] = 1'b1;
    serve(0, 8, 2, 0, 1'b0);
    starve_mode = 1'b0;

    // Store then load, MEM_LAT=2.
    expect_acc(1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    d_we[1] = 1'b1; d_addr[1] = 32'h100; d_wdata[1] = 32'hDEAD_BEEF; d_req[1] = 1'b1;
    serve(1, 1, 0, 0, 1'b1);
    expect_acc(1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    d_we[1] = 1'b0; d_req[1] = 1'b1;
    serve(1, 1, 0, 0, 1'b1);
    repeat (3) @(negedge clk);
    check("d_rdata_hold", d_rdata[1], 32'hDEAD_BEEF);

    // MEM_LAT=3: a completed load, then reset in the middle of WAIT.
    expect_acc(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, init_word(32'h40));
    @(posedge clk); #1;
    d_addr[2] = 32'h40; d_wdata[2] = 32'h1234_5678; d_req[2] = 1'b1;
    serve(2, 1, 0, 0, 1'b1);
    @(negedge clk);
    check("d_rdata_before_reset", d_rdata[2], init_word(32'h40));

    expect_acc(2, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    d_addr[2] = 32'h44; d_req[2] = 1'b1;
    if_addr[2] = 32'h48; if_req[2] = 1'b1;
    seen = 0;
    for (int t = 0; t < 20 && seen == 0; t++) begin
      @(negedge clk);
      if (mem_en[2]) seen = 1;
    end
    check("reset_test_issue_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("state_wait_before_reset", 32'(u[2].dut.state), 32'd2);
    check("starve_before_reset", 32'(u[2].dut.starve_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_addr", mem_addr[2], 32'd0);
    check("async_rst_mem_wdata", mem_wdata[2], 32'd0);
    check("async_rst_d_rdata", d_rdata[2], 32'd0);
    check("async_rst_ready", 32'({if_ready[2], d_ready[2], mem_en[2], mem_we[2]}), 32'd0);
    check("async_rst_state", 32'(u[2].dut.state), 32'd0);
    check("async_rst_starve", 32'(u[2].dut.starve_cnt), 32'd0);
    d_req[2] = 1'b0; if_req[2] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if_ready[2] || d_ready[2]) seen++;
    end
    check("no_ready_after_reset", 32'(seen), 32'd0);

    for (int g = 0; g < N; g++) begin
      check("issue_queue_drained", 32'(issq[g].size()), 32'd0);
      check("rsp_queue_drained", 32'(rspq[g].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
